fb_port_arbiter: RTL



---
 rtl/fb_pkg.sv | 15 +
 rtl/fb_clear_engine.sv | 71 +++++++
 rtl/fb_port_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the port-A FSM state type.
package fb_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 144;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = 15;
  localparam int PIX_W    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_clear_engine.sv
// Clear engine: fills every framebuffer address with one latched value,
// one write per cycle, then pulses done for a single cycle.
module fb_clear_engine
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [PIX_W-1:0]  val_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [PIX_W-1:0]  data_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0]  val_q, val_d;
  logic              done_q, done_d;

  // State, write counter, fill value and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  // Next state: a start in IDLE latches the fill value; CLEAR walks the
  // address space and drops back to IDLE after the last address is written.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
          val_d   = val_i;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == CLEAR);
  assign done_o = done_q;
  assign addr_o = cnt_q;
  assign data_o = val_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Framebuffer port-A owner: arbitrates PPU writes and host accesses,
// hands the port to the clear engine while it runs, and returns host reads.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ppu_valid,
  output logic              ppu_ready,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic [PIX_W-1:0]  ppu_pix,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [PIX_W-1:0]  host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [PIX_W-1:0]  host_rdata,
  input  logic              clr_start,
  input  logic [PIX_W-1:0]  clr_val,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              fb_cea,
  output logic              fb_wrea,
  output logic [ADDR_W-1:0] fb_ada,
  output logic [PIX_W-1:0]  fb_dina,
  input  logic [PIX_W-1:0]  fb_douta,
  output logic              fb_ocea,
  output logic              fb_reseta
);

  localparam int                SC_W       = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(FB_DEPTH);
  localparam logic [SC_W-1:0]   STARVE_LIM = SC_W'(STARVE_MAX);

  logic [ADDR_W-1:0] clr_addr;
  logic [PIX_W-1:0]  clr_data;
  logic              forced;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [RD_LAT-1:0] rd_vld_q, rd_oor_q;
  logic [PIX_W-1:0]  rdata_q;
  logic              rd_ret;
  logic [PIX_W-1:0]  rd_ret_data;

  fb_clear_engine u_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (clr_start),
    .val_i   (clr_val),
    .busy_o  (clr_busy),
    .done_o  (clr_done),
    .addr_o  (clr_addr),
    .data_o  (clr_data)
  );

  assign fb_ocea   = 1'b1;
  assign fb_reseta = 1'b0;

  // Port-A arbitration and RAM drive; out-of-range accesses are handshaken
  // but never enable the RAM.
  always_comb begin
    forced    = 1'b0;
    ppu_ready = 1'b0;
    host_gnt  = 1'b0;
    fb_cea    = 1'b0;
    fb_wrea   = 1'b0;
    fb_ada    = '0;
    fb_dina   = '0;
    if (clr_busy) begin
      fb_cea  = 1'b1;
      fb_wrea = 1'b1;
      fb_ada  = clr_addr;
      fb_dina = clr_data;
    end else begin
      forced    = host_req && (starve_q == STARVE_LIM);
      ppu_ready = ppu_valid && !forced;
      host_gnt  = host_req && !ppu_ready;
      if (ppu_ready) begin
        fb_cea  = (ppu_addr < DEPTH_A);
        fb_wrea = 1'b1;
        fb_ada  = ppu_addr;
        fb_dina = ppu_pix;
      end else if (host_gnt) begin
        fb_cea  = (host_addr < DEPTH_A);
        fb_wrea = host_we;
        fb_ada  = host_addr;
        fb_dina = host_wdata;
      end
    end
  end

  // Starvation count: consecutive denied host cycles, saturating at the limit
  // so a host left waiting through a clear is forced in right afterwards.
  always_comb begin
    starve_d = '0;
    if (host_req && !host_gnt) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Read-return pipeline: tracks each granted host read, and whether it was
  // out of range, until the RAM data is due.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= '0;
      rd_oor_q <= '0;
    end else begin
      rd_vld_q[0] <= host_gnt && !host_we;
      rd_oor_q[0] <= !(host_addr < DEPTH_A);
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_oor_q[i] <= rd_oor_q[i-1];
      end
    end
  end

  assign rd_ret      = rd_vld_q[RD_LAT-1];
  assign rd_ret_data = rd_oor_q[RD_LAT-1] ? '0 : fb_douta;
  assign host_rvalid = rd_ret;
  assign host_rdata  = rd_ret ? rd_ret_data : rdata_q;

  // Hold the last returned read value between returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd_ret) begin
      rdata_q <= rd_ret_data;
    end
  end

endmodule
